// File: rtl/gol_step_scheduler.sv
// rtl/gol_step_scheduler.sv - Game of Life step scheduler: frame-paced step launch, RAM arbitration, buffer swap
module gol_step_scheduler #(
  parameter int PERIOD_W = 8,
  parameter int GEN_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_draw_active,
  input  logic                i_frame_end,
  input  logic                i_run,
  input  logic                i_step,
  input  logic [PERIOD_W-1:0] i_period,
  output logic                o_step_start,
  input  logic                i_step_done,
  input  logic                i_eng_req,
  output logic                o_eng_gnt,
  output logic                o_buf_sel,
  output logic                o_busy,
  output logic [GEN_W-1:0]    o_gen_count
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUNNING   = 2'd1,
    WAIT_SWAP = 2'd2
  } state_t;

  state_t              state, state_next;
  logic [PERIOD_W-1:0] frame_cnt, frame_cnt_next;
  logic                step_pending, step_pending_next;
  logic                start_next;
  logic                swap;
  logic [PERIOD_W-1:0] eff_period;
  logic [PERIOD_W:0]   cnt_plus1;
  logic                start_cond;

  assign eff_period = (i_period == '0) ? PERIOD_W'(1) : i_period;
  assign cnt_plus1  = {1'b0, frame_cnt} + (PERIOD_W + 1)'(1);

  // The +1 counts the frame that is ending right now.
  assign start_cond = i_run ? (cnt_plus1 >= {1'b0, eff_period}) : step_pending;

  always_comb begin
    state_next     = state;
    frame_cnt_next = frame_cnt;
    start_next     = 1'b0;
    swap           = 1'b0;
    case (state)
      IDLE: begin
        if (i_frame_end) begin
          if (start_cond) begin
            state_next     = RUNNING;
            frame_cnt_next = '0;
            start_next     = 1'b1;
          end else if (i_run && !(&frame_cnt)) begin
            frame_cnt_next = cnt_plus1[PERIOD_W-1:0];
          end
        end
      end
      RUNNING: begin
        if (i_step_done) state_next = WAIT_SWAP;
      end
      WAIT_SWAP: begin
        if (i_frame_end) begin
          swap = 1'b1;
          if (start_cond) begin
            state_next     = RUNNING;
            frame_cnt_next = '0;
            start_next     = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Run mode discards any queued single-step; repeated requests collapse.
    if (i_run) step_pending_next = 1'b0;
    else       step_pending_next = (step_pending && !start_next) || i_step;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      frame_cnt    <= '0;
      step_pending <= 1'b0;
      o_step_start <= 1'b0;
      o_buf_sel    <= 1'b0;
      o_gen_count  <= '0;
    end else begin
      state        <= state_next;
      frame_cnt    <= frame_cnt_next;
      step_pending <= step_pending_next;
      o_step_start <= start_next;
      if (swap) begin
        o_buf_sel   <= !o_buf_sel;
        o_gen_count <= o_gen_count + GEN_W'(1);
      end
    end
  end

  // Display reader always wins the RAM; the engine only gets the blanking cycles.
  assign o_eng_gnt = i_eng_req && !i_draw_active && (state == RUNNING);
  assign o_busy    = (state != IDLE);

endmodule

// File: tb/tb_gol_step_scheduler.sv
// tb/tb_gol_step_scheduler.sv - directed vector and frame-sequence bench for gol_step_scheduler
module tb_gol_step_scheduler;

  localparam int FL = 150;

  logic        clk = 1'b0;
  logic        rst;
  logic        draw_active, frame_end, run, step, step_done, eng_req;
  logic [7:0]  period;
  logic        step_start, eng_gnt, buf_sel, busy;
  logic [15:0] gen_count;

  int total = 0;
  int passed = 0;
  int cyc = 0;
  int done_at = -1;

  always #5 clk = ~clk;

  gol_step_scheduler #(.PERIOD_W(8), .GEN_W(16)) dut (
    .clk(clk), .rst(rst),
    .i_draw_active(draw_active), .i_frame_end(frame_end),
    .i_run(run), .i_step(step), .i_period(period),
    .o_step_start(step_start), .i_step_done(step_done),
    .i_eng_req(eng_req), .o_eng_gnt(eng_gnt),
    .o_buf_sel(buf_sel), .o_busy(busy), .o_gen_count(gen_count)
  );

  typedef struct packed {
    logic        de, fe, run, st, dn, rq;
    logic [7:0]  per;
    logic        ss, gnt, bs, busy;
    logic [15:0] gc;
  } vec_t;

  vec_t tbl [23];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic do_reset(input logic r_run, input logic [7:0] r_per);
    @(negedge clk);
    rst = 1'b1; draw_active = 1'b0; frame_end = 1'b0; step = 1'b0;
    step_done = 1'b0; eng_req = 1'b0; run = r_run; period = r_per;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    done_at = -1;
    #1;
    check("rst_step_start", step_start, 0);
    check("rst_buf_sel", buf_sel, 0);
    check("rst_gen_count", gen_count, 0);
    check("rst_busy", busy, 0);
  endtask

  // One frame: frame_end in its first cycle, behavioural engine finishing 100 cycles after each start.
  task automatic frame(input string tag, input bit e_ss, input bit e_bs, input int e_gc, input bit step_mid);
    int starts = 0;
    for (int c = 0; c < FL; c++) begin
      @(negedge clk);
      frame_end = (c == 0);
      step      = step_mid && (c == 20 || c == 40);
      step_done = (cyc == done_at);
      #1;
      if (c == 1) begin
        check({tag, "_start"}, step_start, e_ss);
        check({tag, "_buf_sel"}, buf_sel, e_bs);
        check({tag, "_gen_count"}, gen_count, e_gc);
      end
      if (step_start) begin
        starts++;
        done_at = cyc + 100;
      end
      cyc++;
    end
    frame_end = 1'b0; step = 1'b0; step_done = 1'b0;
    check({tag, "_start_count"}, starts, e_ss);
  endtask

  initial begin
    rst = 1'b1; draw_active = 1'b0; frame_end = 1'b0; run = 1'b0; step = 1'b0;
    step_done = 1'b0; eng_req = 1'b0; period = 8'd0;

    //          de fe run st dn rq per    ss gnt bs busy gc
    tbl[0]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,8'd0, 1'b0,1'b0,1'b0,1'b0,16'd0};
    tbl[1]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,8'd0, 1'b0,1'b0,1'b0,1'b0,16'd0};
    tbl[2]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,8'd0, 1'b1,1'b1,1'b0,1'b1,16'd0};
    tbl[3]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,8'd0, 1'b0,1'b0,1'b0,1'b1,16'd0};
    tbl[4]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,8'd0, 1'b0,1'b1,1'b0,1'b1,16'd0};
    tbl[5]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,8'd0, 1'b0,1'b0,1'b0,1'b1,16'd0};
    tbl[6]  = '{1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,8'd0, 1'b0,1'b1,1'b0,1'b1,16'd0};
    tbl[7]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,8'd0, 1'b0,1'b0,1'b0,1'b1,16'd0};
    tbl[8]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,8'd0, 1'b0,1'b0,1'b0,1'b1,16'd0};
    tbl[9]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,8'd0, 1'b1,1'b0,1'b1,1'b1,16'd1};
    tbl[10] = '{1'b0,1'b1,1'b1,1'b0,1'b1,1'b0,8'd0, 1'b0,1'b0,1'b1,1'b1,16'd1};
    tbl[11] = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,8'd0, 1'b0,1'b0,1'b1,1'b1,16'd1};
    tbl[12] = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,8'd0, 1'b0,1'b0,1'b1,1'b1,16'd1};
    tbl[13] = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,8'd0, 1'b1,1'b0,1'b0,1'b1,16'd2};
    tbl[14] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,8'd0, 1'b0,1'b0,1'b0,1'b1,16'd2};
    tbl[15] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,8'd0, 1'b0,1'b0,1'b0,1'b1,16'd2};
    tbl[16] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,8'd0, 1'b0,1'b0,1'b0,1'b1,16'd2};
    tbl[17] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'd0, 1'b1,1'b0,1'b1,1'b1,16'd3};
    tbl[18] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,8'd0, 1'b0,1'b0,1'b1,1'b1,16'd3};
    tbl[19] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,8'd0, 1'b0,1'b0,1'b1,1'b1,16'd3};
    tbl[20] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,8'd0, 1'b0,1'b0,1'b0,1'b0,16'd4};
    tbl[21] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,8'd0, 1'b0,1'b0,1'b0,1'b0,16'd4};
    tbl[22] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'd0, 1'b0,1'b0,1'b0,1'b0,16'd4};

    // Per-cycle vectors: arbitration, coincident done/frame_end, paused single step.
    do_reset(1'b1, 8'd0);
    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      draw_active = tbl[i].de; frame_end = tbl[i].fe; run = tbl[i].run;
      step = tbl[i].st; step_done = tbl[i].dn; eng_req = tbl[i].rq; period = tbl[i].per;
      #1;
      check($sformatf("v%0d_step_start", i), step_start, tbl[i].ss);
      check($sformatf("v%0d_eng_gnt", i), eng_gnt, tbl[i].gnt);
      check($sformatf("v%0d_buf_sel", i), buf_sel, tbl[i].bs);
      check($sformatf("v%0d_busy", i), busy, tbl[i].busy);
      check($sformatf("v%0d_gen_count", i), gen_count, tbl[i].gc);
    end

    // Free-running, period 3: starts after frame_ends 3,7,11; swaps at 4,8.
    do_reset(1'b1, 8'd3);
    for (int n = 1; n <= 12; n++)
      frame($sformatf("p3_f%0d", n), (n % 4) == 3, ((n / 4) % 2) == 1, n / 4, 1'b0);

    // Paused: two step requests mid-frame give exactly one start.
    do_reset(1'b0, 8'd1);
    frame("ss_f1", 1'b0, 1'b0, 0, 1'b1);
    frame("ss_f2", 1'b1, 1'b0, 0, 1'b0);
    frame("ss_f3", 1'b0, 1'b1, 1, 1'b0);
    frame("ss_f4", 1'b0, 1'b1, 1, 1'b0);

    // Period 0 acts as 1: swap and restart on every frame_end after the first.
    do_reset(1'b1, 8'd0);
    frame("p0_f1", 1'b1, 1'b0, 0, 1'b0);
    for (int n = 2; n <= 6; n++)
      frame($sformatf("p0_f%0d", n), 1'b1, (n % 2) == 0, n - 1, 1'b0);

    // Engine finished in frame 6 -> WAIT_SWAP with buf_sel=1, gen_count=5; reset now.
    #1;
    check("pre_rst_busy", busy, 1);
    check("pre_rst_buf_sel", buf_sel, 1);
    check("pre_rst_gen_count", gen_count, 5);
    @(negedge clk);
    rst = 1'b1;
    frame_end = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    frame_end = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_buf_sel", buf_sel, 0);
    check("mid_rst_gen_count", gen_count, 0);
    check("mid_rst_step_start", step_start, 0);
    @(negedge clk);
    #1;
    check("post_rst_step_start", step_start, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
